// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter and its verification monitors.
package wb_pkg;

  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_ADDR_WIDTH = 5;

  // Which producer, if any, transfers in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_MEM  = 2'd2
  } grant_e;

endpackage : wb_pkg

// File: rtl/wb_bypass.sv
// Single-port operand bypass from the writeback register to a decode read port.
// Compiled only when WB_FORWARD_EN is defined.
`ifdef WB_FORWARD_EN
module wb_bypass
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] data_c_o
);

  // x0 reads as zero; a pending write to the same index wins over the stale file value.
  always_comb begin
    data_c_o = rf_data_i;
    if (rs_i == '0) begin
      data_c_o = '0;
    end else if (wb_we_i && (wb_rd_i == rs_i)) begin
      data_c_o = wb_data_i;
    end
  end

endmodule : wb_bypass
`endif

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file
// write port with memory priority bounded by an ALU starvation counter.
// Optional operand bypass ports are enabled by defining WB_FORWARD_EN.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = WB_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_write_data
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic                  starve_hit;
  grant_e                grant;

  // Ready generation: memory first unless the ALU has waited STARVE_LIMIT cycles.
  always_comb begin
    starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    mem_ready  = rst_n && !(alu_valid && starve_hit);
    alu_ready  = rst_n && (!mem_valid || starve_hit);
  end

  // Grant selection, starvation counter and output register next state.
  always_comb begin
    grant        = GRANT_NONE;
    starve_cnt_d = '0;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_data_d    = rf_data_q;

    if (alu_valid && alu_ready) begin
      grant = GRANT_ALU;
    end else if (mem_valid && mem_ready) begin
      grant = GRANT_MEM;
    end

    if (alu_valid && !alu_ready) begin
      starve_cnt_d = starve_hit ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end

    case (grant)
      GRANT_ALU: begin
        rf_rd_d   = alu_rd;
        rf_data_d = alu_data;
        rf_we_d   = (alu_rd != '0);
      end
      GRANT_MEM: begin
        rf_rd_d   = mem_rd;
        rf_data_d = mem_data;
        rf_we_d   = (mem_rd != '0);
      end
      default: ;
    endcase
  end

  // State registers; reset drops any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign rf_write_enable = rf_we_q;
  assign rf_rd           = rf_rd_q;
  assign rf_write_data   = rf_data_q;

`ifdef WB_FORWARD_EN
  // Operand bypass for both decode read ports.
  wb_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bypass_rs1 (
    .rs_i     (rs1),
    .rf_data_i(rf_rs1_data),
    .wb_we_i  (rf_we_q),
    .wb_rd_i  (rf_rd_q),
    .wb_data_i(rf_data_q),
    .data_c_o (rs1_data)
  );

  wb_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bypass_rs2 (
    .rs_i     (rs2),
    .rf_data_i(rf_rs2_data),
    .wb_we_i  (rf_we_q),
    .wb_rd_i  (rf_rd_q),
    .wb_data_i(rf_data_q),
    .data_c_o (rs2_data)
  );
`endif

endmodule : writeback_arbiter

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed steps plus randomized producers
// checked against a transaction-level reference model.
module tb_writeback_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, rf_rd;
  logic [DW-1:0] alu_data, mem_data, rf_write_data;
  logic          rf_write_enable;
`ifdef WB_FORWARD_EN
  logic [AW-1:0] rs1, rs2;
  logic [DW-1:0] rf_rs1_data, rf_rs2_data, rs1_data, rs2_data;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state: how long the ALU has been refused, and the expected write port.
  int            alu_wait;
  logic          exp_we;
  logic [AW-1:0] exp_rd;
  logic [DW-1:0] exp_data;
  int            last_win; // 0 none, 1 alu, 2 mem

  always #5 clk = ~clk;

  writeback_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .rf_write_enable(rf_write_enable),
    .rf_rd          (rf_rd),
    .rf_write_data  (rf_write_data)
`ifdef WB_FORWARD_EN
    ,
    .rs1            (rs1),
    .rs2            (rs2),
    .rf_rs1_data    (rf_rs1_data),
    .rf_rs2_data    (rf_rs2_data),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port();
    chk("rf_write_enable", 32'(rf_write_enable), 32'(exp_we));
    chk("rf_rd", 32'(rf_rd), 32'(exp_rd));
    chk("rf_write_data", rf_write_data, exp_data);
  endtask

  // One cycle: drive after negedge, check readies, let the edge happen, check the write port.
  task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                      input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
    logic e_ar, e_mr, starving;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    starving = (alu_wait >= int'(LIMIT));
    // ALU may go when memory is idle or it has been refused LIMIT times in a row.
    e_ar = !mv || starving;
    // Memory may go unless a starved ALU is waiting.
    e_mr = !(av && starving);
    chk("alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("mem_ready", 32'(mem_ready), 32'(e_mr));
    last_win = 0;
    if (av && e_ar) last_win = 1;
    else if (mv && e_mr) last_win = 2;
    if (av && last_win != 1) alu_wait = (alu_wait + 1 > int'(LIMIT)) ? int'(LIMIT) : alu_wait + 1;
    else alu_wait = 0;
    exp_we = 1'b0;
    if (last_win == 1) begin exp_rd = ard; exp_data = ad; exp_we = (ard != 0); end
    if (last_win == 2) begin exp_rd = mrd; exp_data = md; exp_we = (mrd != 0); end
    @(posedge clk);
    #1;
    chk_port();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic          ap, mp;
    logic [AW-1:0] rard, rmrd;
    logic [DW-1:0] rad, rmd;

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_FORWARD_EN
    rs1 = '0; rs2 = '0; rf_rs1_data = '0; rf_rs2_data = '0;
`endif
    alu_wait = 0; exp_we = 1'b0; exp_rd = '0; exp_data = '0; last_win = 0;

    // Reset state.
    #3;
    chk("reset_we", 32'(rf_write_enable), 32'd0);
    chk("reset_rd", 32'(rf_rd), 32'd0);
    chk("reset_data", rf_write_data, 32'd0);
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("reset_alu_ready", 32'(alu_ready), 32'd0);
    chk("reset_mem_ready", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write, then an idle cycle that holds rd/data with the strobe low.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("single_rd", 32'(rf_rd), 32'd5);
    idle();
    chk("single_we_drop", 32'(rf_write_enable), 32'd0);

    // Contention: four memory writes then one ALU write, repeating.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 5'd3, 32'hA000_0000 + 32'(i), 1'b1, 5'd4, 32'hB000_0000 + 32'(i));
      chk("contention_order", 32'(rf_rd), (i % 5 == 4) ? 32'd3 : 32'd4);
    end
    idle();

    // Write to x0 is consumed but never strobes.
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    chk("x0_we", 32'(rf_write_enable), 32'd0);
    chk("x0_data", rf_write_data, 32'h1234);

    // Streaming memory writes with no gaps.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b1, 5'(i + 1), 32'hC000_0000 + 32'(i));
      chk("stream_we", 32'(rf_write_enable), 32'd1);
    end
    idle();

`ifdef WB_FORWARD_EN
    // Bypass: pending write to x7 overrides the stale file value; x0 reads zero.
    step(1'b1, 5'd7, 32'hCAFE0001, 1'b0, '0, '0);
    rs1 = 5'd7; rf_rs1_data = 32'h0; rs2 = 5'd0; rf_rs2_data = 32'h55;
    #1;
    chk("fwd_rs1", rs1_data, 32'hCAFE0001);
    chk("fwd_rs2_x0", rs2_data, 32'h0);
    rs2 = 5'd8; rf_rs2_data = 32'h66;
    #1;
    chk("fwd_rs2_nomatch", rs2_data, 32'h66);
    idle();
    rf_rs1_data = 32'h11;
    #1;
    chk("fwd_rs1_no_we", rs1_data, 32'h11);
`endif

    // Randomized producers honouring the hold-while-waiting rule.
    ap = 1'b0; mp = 1'b0; rard = '0; rmrd = '0; rad = '0; rmd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ap && $urandom_range(0, 3) != 0) begin
        ap = 1'b1; rard = 5'($urandom); rad = $urandom;
      end
      if (!mp && $urandom_range(0, 4) != 0) begin
        mp = 1'b1; rmrd = 5'($urandom); rmd = $urandom;
      end
      step(ap, rard, rad, mp, rmrd, rmd);
      if (last_win == 1) ap = 1'b0;
      if (last_win == 2) mp = 1'b0;
    end

    // Asynchronous reset mid-cycle with a write pending and a result in flight.
    step(1'b1, 5'd9, 32'h9999_0009, 1'b0, '0, '0);
    alu_valid = 1'b0; mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hAAAA;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(rf_write_enable), 32'd0);
    chk("arst_rd", 32'(rf_rd), 32'd0);
    chk("arst_data", rf_write_data, 32'd0);
    chk("arst_mem_ready", 32'(mem_ready), 32'd0);
    chk("arst_alu_ready", 32'(alu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_we", 32'(rf_write_enable), 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    rst_n = 1'b1;
    alu_wait = 0; exp_we = 1'b0; exp_rd = '0; exp_data = '0;
    idle();

    // First transfer right after release.
    step(1'b0, '0, '0, 1'b1, 5'd12, 32'h0BAD_F00D);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_writeback_arbiter

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that sits directly upstream of the integer register file and owns its single write port. It merges results from two producers, the single-cycle ALU and the load/memory unit, using valid/ready handshakes and a starvation-bounded fixed priority. It registers the winning result onto the register-file write port, so the file sees one write per cycle.

## Interface
- DATA_WIDTH, 32, result/register width
- ADDR_WIDTH, 5, register index width
- STARVE_LIMIT, 4, max consecutive cycles ALU may be blocked by memory; must be ≥1

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load result available
- mem_ready  out  1  load result accepted this cycle when high with mem_valid
- mem_rd  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- rf_write_enable  out  1  register-file write strobe
- rf_rd  out  ADDR_WIDTH  register-file write index
- rf_write_data  out  DATA_WIDTH  register-file write data
- Present only with WB_FORWARD_EN:
  - rs1, rs2  in  ADDR_WIDTH  decode read indices
  - rf_rs1_data, rf_rs2_data  in  DATA_WIDTH  raw register-file read data
  - rs1_data, rs2_data  out  DATA_WIDTH  bypassed operands

## Operation
- Transfer on a channel: valid && ready at a rising edge.
- Memory has priority. The starvation counter starve_cnt, width $clog2(STARVE_LIMIT+1), overrides it when the ALU has waited too long.
- Ready logic is combinational and never depends on the channel's own valid:
  - starve_hit = (starve_cnt == STARVE_LIMIT)
  - mem_ready = rst_n && !(alu_valid && starve_hit)
  - alu_ready = rst_n && (!mem_valid || starve_hit)
- Exactly one channel transfers when both are valid. Neither transfers when neither is valid.
- starve_cnt update:
  - Increments (saturating at STARVE_LIMIT) when alu_valid && !alu_ready.
  - Clears when the ALU transfers or alu_valid is low.
- On a transfer, the output register loads the winner's rd/data into rf_rd/rf_write_data.
- rf_write_enable is set to (rd != 0). A write to x0 is accepted and consumed but never asserts the strobe.
- No transfer in a cycle: rf_write_enable is 0 next cycle; rf_rd/rf_write_data hold their values.
- Producers must hold rd/data stable while valid && !ready.

## Timing
- Latency: a transfer at edge N gives rf_write_enable/rf_rd/rf_write_data valid throughout cycle N+1. The register file commits at edge N+1.
- Throughput: one write per cycle, no bubbles between back-to-back transfers.
- Reset (asynchronous, any time):
  - rf_write_enable=0, rf_rd=0, rf_write_data=0, starve_cnt=0.
  - alu_ready=mem_ready=0 while rst_n is low.
  - A result in flight at reset is discarded.
- First transfer is possible at the first rising edge after rst_n deasserts.
- Fairness with both channels continuously valid: memory, memory, … (STARVE_LIMIT times), then ALU. The pattern repeats.

## Configuration
- WB_FORWARD_EN defined: bypass ports exist.
  - rsX_data = 0 if rsX == 0.
  - Otherwise rsX_data = rf_write_data if rf_write_enable && rf_rd == rsX.
  - Otherwise rsX_data = rf_rsX_data.
  - Purely combinational; covers the cycle in which the file still returns the old value.
- WB_FORWARD_EN undefined: bypass ports and logic are absent; decode reads the register file directly.

## Structure
- Shared package wb_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants
  - grant enum (GRANT_NONE, GRANT_ALU, GRANT_MEM) used by the arbiter and by verification monitors
- Sub-module wb_bypass contains the single-port forwarding mux. It is instantiated twice (rs1, rs2) under WB_FORWARD_EN.

## Test plan
- Reset: assert rst_n low mid-cycle while a write is pending -> rf_write_enable, rf_rd and rf_write_data drop to 0 immediately; both readies are 0; no write occurs after release.
- Single write: alu_valid with rd=5, data=0xDEADBEEF accepted at edge N -> cycle N+1 shows rf_write_enable=1, rf_rd=5, rf_write_data=0xDEADBEEF; cycle N+2 shows rf_write_enable=0.
- Contention: both channels valid continuously (alu rd=3, mem rd=4), STARVE_LIMIT=4 -> accepted sequence mem, mem, mem, mem, alu, repeating; alu_ready high only on every 5th cycle.
- x0 write: mem_valid with rd=0, data=0x1234 -> mem_ready=1 and transfer occurs; rf_write_enable stays 0 the next cycle.
- Streaming: mem_valid held 8 cycles with alu_valid=0 -> 8 consecutive cycles with rf_write_enable=1, no gaps.
- Forwarding (WB_FORWARD_EN): output register holds rd=7, 0xCAFE0001 with rs1=7, rf_rs1_data=0 -> rs1_data=0xCAFE0001; rs2=0 -> rs2_data=0.
